// File: rtl/division_controller.sv
// Sequencing FSM for a shift/subtract divider supporting restoring and non-restoring modes.
// Quotient bits are inserted one shift late, so a final Q-only shift (QFIX) flushes the last bit.
module division_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       dvz,
  input  logic       Co,
  input  logic       SignSum,
  output logic [1:0] QCommand,
  output logic [1:0] ACommand,
  output logic [1:0] MCommand,
  output logic       subtractFlag,
  output logic       cntEn,
  output logic       ldCnt,
  output logic       Ci,
  output logic       SiR_Q,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] CmdHold  = 2'b00;
  localparam logic [1:0] CmdLoad  = 2'b01;
  localparam logic [1:0] CmdShift = 2'b10;
  localparam logic [1:0] CmdClear = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StOp,
    StQfix,
    StCorr,
    StDone
  } state_e;

  state_e r_state;
  logic   r_qbit;
  logic   r_sgn;
  logic   r_mode;
  logic   r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_qbit  <= 1'b0;
      r_sgn   <= 1'b0;
      r_mode  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_state <= StLoad;
            r_mode  <= mode;
            r_err   <= 1'b0;
          end
        end
        StLoad: begin
          r_qbit  <= 1'b0;
          r_sgn   <= 1'b0;
          r_err   <= dvz;
          r_state <= dvz ? StDone : StShift;
        end
        StShift: r_state <= StOp;
        StOp: begin
          // Both modes take the quotient bit from the sign of the trial result.
          r_qbit <= ~SignSum;
          if (r_mode) begin
            r_sgn <= SignSum;
          end
          r_state <= Co ? StQfix : StShift;
        end
        StQfix:  r_state <= StCorr;
        StCorr:  r_state <= StDone;
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    QCommand     = CmdHold;
    ACommand     = CmdHold;
    MCommand     = CmdHold;
    subtractFlag = 1'b0;
    cntEn        = 1'b0;
    ldCnt        = 1'b0;
    Ci           = 1'b0;
    SiR_Q        = 1'b0;
    done         = 1'b0;
    busy         = (r_state != StIdle);
    unique case (r_state)
      StIdle: begin
      end
      StLoad: begin
        QCommand = CmdLoad;
        ACommand = CmdClear;
        MCommand = CmdLoad;
        ldCnt    = 1'b1;
      end
      StShift: begin
        QCommand = CmdShift;
        ACommand = CmdShift;
        SiR_Q    = r_qbit;
      end
      StOp: begin
        cntEn = 1'b1;
        Ci    = 1'b1;
        if (r_mode) begin
          subtractFlag = ~r_sgn;
          ACommand     = CmdLoad;
        end else begin
          // Restoring: only commit the difference when it stayed non-negative.
          subtractFlag = 1'b1;
          ACommand     = SignSum ? CmdHold : CmdLoad;
        end
      end
      StQfix: begin
        QCommand = CmdShift;
        SiR_Q    = r_qbit;
      end
      StCorr: begin
        if (r_mode && r_sgn) begin
          ACommand     = CmdLoad;
          subtractFlag = 1'b0;
        end
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign err = r_err;

endmodule

// File: tb/tb_division_controller.sv
// Drives division_controller against a behavioural Q/A/M/counter datapath and checks the
// resulting quotient and remainder against integer division.
module tb_division_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic       dvz;
  logic       Co;
  logic       SignSum;
  logic [1:0] QCommand;
  logic [1:0] ACommand;
  logic [1:0] MCommand;
  logic       subtractFlag;
  logic       cntEn;
  logic       ldCnt;
  logic       Ci;
  logic       SiR_Q;
  logic       busy;
  logic       done;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [9:0]  dividend = '0;
  logic [9:0]  divisor_v = '0;
  logic [9:0]  dp_q = '0;
  logic [11:0] dp_a = '0;
  logic [11:0] dp_m = '0;
  logic [3:0]  dp_cnt = '0;
  logic [11:0] w_sum;

  division_controller dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .dvz          (dvz),
    .Co           (Co),
    .SignSum      (SignSum),
    .QCommand     (QCommand),
    .ACommand     (ACommand),
    .MCommand     (MCommand),
    .subtractFlag (subtractFlag),
    .cntEn        (cntEn),
    .ldCnt        (ldCnt),
    .Ci           (Ci),
    .SiR_Q        (SiR_Q),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: 10-bit Q, 12-bit signed A and M, 4-bit counter.
  assign w_sum   = subtractFlag ? (dp_a - dp_m) : (dp_a + dp_m);
  assign SignSum = w_sum[11];
  assign Co      = (dp_cnt == 4'd15) && Ci;
  assign dvz     = (divisor_v == 10'd0);

  always @(posedge clk) begin
    case (QCommand)
      2'b01:   dp_q <= dividend;
      2'b10:   dp_q <= {dp_q[8:0], SiR_Q};
      2'b11:   dp_q <= '0;
      default: dp_q <= dp_q;
    endcase
    case (ACommand)
      2'b01:   dp_a <= w_sum;
      2'b10:   dp_a <= {dp_a[10:0], dp_q[9]};
      2'b11:   dp_a <= '0;
      default: dp_a <= dp_a;
    endcase
    if (MCommand == 2'b01) dp_m <= {2'b00, divisor_v};
    if (ldCnt) dp_cnt <= 4'd6;
    else if (cntEn) dp_cnt <= dp_cnt + {3'b000, Ci};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int outs_word();
    return int'({QCommand, ACommand, MCommand, subtractFlag, cntEn, ldCnt, Ci, SiR_Q,
                 busy, done, err});
  endfunction

  // One operation from a start pulse in cycle 0; exp_corr < 0 skips the CORR-add check.
  task automatic run_div(input logic [9:0] a, input logic [9:0] b, input logic m,
                         input bit pulses, input int exp_corr, input string tag);
    int         done_cyc = -1;
    int         n_done = 0;
    int         n_shift = 0;
    int         n_corr = 0;
    int         q_at = 0;
    int         a_at = 0;
    int         err_at = 0;
    @(posedge clk); #1;
    dividend  = a;
    divisor_v = b;
    mode      = m;
    start     = 1'b1;
    for (int cyc = 1; cyc <= 27; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start = 1'b0;
      if (pulses && (cyc == 5 || cyc == 23)) begin
        start = 1'b1;
        mode  = ~m;
      end
      if (pulses && (cyc == 6 || cyc == 24)) start = 1'b0;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          q_at     = int'(dp_q);
          a_at     = int'(dp_a);
          err_at   = int'(err);
        end
      end
      if (QCommand == 2'b10 && ACommand == 2'b10) n_shift++;
      if (ACommand == 2'b01 && !subtractFlag && !cntEn) n_corr++;
    end
    mode = m;
    check({tag, " done_count"}, n_done, 1);
    if (b == 10'd0) begin
      check({tag, " done_cycle"}, done_cyc, 2);
      check({tag, " err"}, err_at, 1);
      check({tag, " shifts"}, n_shift, 0);
    end else begin
      check({tag, " done_cycle"}, done_cyc, 24);
      check({tag, " err"}, err_at, 0);
      check({tag, " shifts"}, n_shift, 10);
      check({tag, " Q"}, q_at, int'(a) / int'(b));
      check({tag, " A"}, a_at, int'(a) % int'(b));
      if (exp_corr >= 0) check({tag, " corr_adds"}, n_corr, exp_corr);
    end
  endtask

  initial begin
    int n_done;
    int done_cyc[2];
    int q_res[2];
    int a_res[2];
    logic [9:0] ra;
    logic [9:0] rb;

    rst   = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    #1;
    check("reset_outputs_t0", outs_word(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_held", outs_word(), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs", outs_word(), 0);

    run_div(10'd100, 10'd7, 1'b0, 1'b0, 0, "rest_100_7");
    run_div(10'd1023, 10'd31, 1'b1, 1'b0, -1, "nr_1023_31");
    run_div(10'd5, 10'd9, 1'b1, 1'b0, 1, "nr_5_9");
    run_div(10'd55, 10'd0, 1'b0, 1'b0, -1, "dvz_rest");
    run_div(10'd55, 10'd0, 1'b1, 1'b0, -1, "dvz_nr");
    run_div(10'd100, 10'd7, 1'b0, 1'b1, 0, "pulses_rest");
    run_div(10'd5, 10'd9, 1'b1, 1'b1, 1, "pulses_nr");

    // Reset in cycle 10 of an operation.
    n_done = 0;
    @(posedge clk); #1;
    dividend  = 10'd777;
    divisor_v = 10'd3;
    mode      = 1'b1;
    start     = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start = 1'b0;
      if (done) n_done++;
    end
    check("mid_op_busy_before_reset", int'(busy), 1);
    rst = 1'b0;
    #1;
    check("mid_reset_busy", int'(busy), 0);
    check("mid_reset_outputs", outs_word(), 0);
    repeat (3) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    rst = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("mid_reset_no_done", n_done, 0);
    run_div(10'd777, 10'd3, 1'b1, 1'b0, -1, "after_reset_nr");
    run_div(10'd777, 10'd3, 1'b0, 1'b0, 0, "after_reset_rest");

    // Back-to-back with start held high, restoring then non-restoring.
    n_done = 0;
    done_cyc = '{-1, -1};
    q_res = '{0, 0};
    a_res = '{0, 0};
    @(posedge clk); #1;
    dividend  = 10'd200;
    divisor_v = 10'd13;
    mode      = 1'b0;
    start     = 1'b1;
    for (int cyc = 1; cyc <= 52; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        if (n_done < 2) begin
          done_cyc[n_done] = cyc;
          q_res[n_done]    = int'(dp_q);
          a_res[n_done]    = int'(dp_a);
        end
        n_done++;
      end
      if (cyc == 24) begin
        dividend  = 10'd900;
        divisor_v = 10'd37;
        mode      = 1'b1;
      end
      if (cyc == 26) start = 1'b0;
    end
    check("b2b_done_count", n_done, 2);
    check("b2b_done_cycle0", done_cyc[0], 24);
    check("b2b_done_cycle1", done_cyc[1], 49);
    check("b2b_Q0", q_res[0], 200 / 13);
    check("b2b_A0", a_res[0], 200 % 13);
    check("b2b_Q1", q_res[1], 900 / 37);
    check("b2b_A1", a_res[1], 900 % 37);

    for (int i = 0; i < 10; i++) begin
      ra = 10'($urandom_range(1023, 0));
      if (i % 2 == 0) rb = 10'($urandom_range(15, 1));
      else rb = 10'($urandom_range(1023, 1));
      run_div(ra, rb, 1'($urandom_range(1, 0)), 1'b0, -1, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/division_controller.md
DIVISION_CONTROLLER -- requirements
Module: division_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst.
REQ-002 clk  input  1  rising-edge clock, shared with the datapath.
REQ-003 rst  input  1  asynchronous active-low reset; asserted when 0.
REQ-004 start  input  1  begin a division; sampled in IDLE only.
REQ-005 mode  input  1  0 = restoring, 1 = non-restoring; sampled with start and held internally for the whole operation.
REQ-006 dvz  input  1  divisor-is-zero flag from the datapath.
REQ-007 Co  input  1  counter carry-out (count = 15 and Ci = 1).
REQ-008 SignSum  input  1  sign bit of the adder/subtractor result.
REQ-009 QCommand, ACommand, MCommand  output  2 each  shift-register mode: 00 hold, 01 parallel load, 10 shift left, 11 clear.
REQ-010 subtractFlag  output  1  1 = A-M, 0 = A+M.
REQ-011 cntEn, ldCnt, Ci  output  1 each  counter enable, load-6, carry-in.
REQ-012 SiR_Q  output  1  serial input to the Q LSB.
REQ-013 busy  output  1  operation in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  divide-by-zero flag; valid while done = 1.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SHIFT, OP, QFIX, CORR and DONE, plus two internal flags: qbit and sgn.
REQ-017 IDLE: all commands SHALL be 00 and all strobes 0; start = 1 SHALL go to LOAD, otherwise the FSM stays in IDLE.
REQ-018 LOAD: QCommand = 01, ACommand = 11, MCommand = 01 and ldCnt = 1; qbit and sgn SHALL be cleared.
REQ-019 LOAD exit: go to DONE with err = 1 if dvz = 1, otherwise go to SHIFT.
REQ-020 SHIFT: QCommand = 10 and ACommand = 10, with SiR_Q = qbit; the next state SHALL be OP.
REQ-021 OP, restoring mode: subtractFlag = 1.
REQ-022 OP, restoring mode: if SignSum = 0 then ACommand = 01 and qbit <= 1; if SignSum = 1 then ACommand = 00 and qbit <= 0.
REQ-023 OP, non-restoring mode: subtractFlag = ~sgn and ACommand = 01, with qbit <= ~SignSum and sgn <= SignSum.
REQ-024 OP, both modes: cntEn = 1 and Ci = 1; the next state SHALL be QFIX if Co = 1, otherwise SHIFT.
REQ-025 The loop SHALL run exactly 10 iterations: the counter counts from 6 to 15, and Co is seen in the 10th OP.
REQ-026 QFIX: QCommand = 10, ACommand = 00, SiR_Q = qbit; this inserts the final quotient bit, the first inserted bit having already left the MSB; the next state SHALL be CORR.
REQ-027 CORR: if mode = 1 and sgn = 1, then ACommand = 01 with subtractFlag = 0, giving the remainder correction A + M; otherwise ACommand = 00; the next state SHALL be DONE.
REQ-028 DONE: done = 1 for exactly one cycle, all commands 00; the next state SHALL be IDLE.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 Latency: the start edge is cycle 0 and done = 1 in cycle 24 (LOAD, then 20 SHIFT/OP cycles, QFIX, CORR, DONE).
REQ-031 The dvz path SHALL give done in cycle 2.
REQ-032 start asserted while busy = 1 SHALL be ignored; start held high SHALL begin a new operation in the cycle after DONE.
REQ-033 All outputs SHALL be decoded combinationally from the state, mode, qbit, sgn and SignSum.
REQ-034 qbit and sgn SHALL update only on the edge that leaves OP.
REQ-035 The stored mode SHALL be ignored outside an operation.

Reset
REQ-036 rst = 0 SHALL force IDLE asynchronously and clear qbit, sgn, the stored mode and err.
REQ-037 During reset all commands SHALL be 00 and busy, done and strobes 0.
REQ-038 Reset mid-operation SHALL abort without a done pulse; the next start SHALL run a full 24-cycle operation.

Verification
REQ-039 Restoring, dividend 100, divisor 7, start -> done in cycle 24: Q = 14, A = 2, err = 0.
REQ-040 Non-restoring, dividend 1023, divisor 31 -> Q = 33, A = 0; and dividend 5, divisor 9 -> Q = 0, A = 5, with the CORR add exercised.
REQ-041 divisor 0, dvz = 1 -> done in cycle 2 with err = 1; no SHIFT or OP occurs.
REQ-042 Pulse start again in cycles 5 and 23 -> both ignored, exactly one done.
REQ-043 Drop rst in cycle 10 -> busy = 0 immediately and no done; the next start gives correct results.
REQ-044 Back-to-back operations with start held high -> done in cycles 24 and 49, both mode values covered.
